// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-number type, the r0 constant, controller state encoding.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_t;

    // r0 is hard-wired to zero, so it can never carry a real dependency.
    localparam reg_t R0 = '0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // True when a used source register is produced by the given destination.
    function automatic logic src_hit(input reg_t src, input logic use_src, input reg_t rd);
        return use_src && (rd != R0) && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and its controller: hazard inputs out, register controls back.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller answers combinationally within the same cycle.
//   master: datapath side (drives instruction fields, receives hold/clear controls)
//   slave : controller side (pipe_ctrl)
interface pipe_ctrl_if;
    import cpu_pkg::*;

    // ID instruction sources
    reg_t id_rs;
    reg_t id_rt;
    logic id_use_rs;
    logic id_use_rt;
    logic id_branch;
    // EX / MEM destinations
    reg_t ex_rd;
    logic ex_regwrite;
    logic ex_memread;
    reg_t mem_rd;
    logic mem_memread;
    // redirects, mul/div start, memory wait
    logic br_taken;
    logic jump;
    logic md_start;
    logic ext_stall;
    // pipeline register controls
    logic pc_hold;
    logic ifid_hold;
    logic ifid_clear;
    logic idex_hold;
    logic idex_clear;
    logic exmem_hold;
    logic exmem_clear;
    logic memwb_hold;
    logic md_done;
    logic busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
        output ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread,
        output br_taken, jump, md_start, ext_stall,
        input  pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
        input  exmem_hold, exmem_clear, memwb_hold, md_done, busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
        input  ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread,
        input  br_taken, jump, md_start, ext_stall,
        output pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
        output exmem_hold, exmem_clear, memwb_hold, md_done, busy
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Source/destination comparisons for load-use and branch-operand hazards (r0 never matches).
// Latency: purely combinational, same cycle.
// Backpressure: none; results are consumed by pipe_ctrl which decides the stall.
//   in : ID sources/use flags/branch flag, EX rd/regwrite/memread, MEM rd/memread
//   out: load_use, branch_dep
module hazard_detect
    import cpu_pkg::*;
(
    input  reg_t id_rs,
    input  reg_t id_rt,
    input  logic id_use_rs,
    input  logic id_use_rt,
    input  logic id_branch,
    input  reg_t ex_rd,
    input  logic ex_regwrite,
    input  logic ex_memread,
    input  reg_t mem_rd,
    input  logic mem_memread,
    output logic load_use,
    output logic branch_dep
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = src_hit(id_rs, id_use_rs, ex_rd)  || src_hit(id_rt, id_use_rt, ex_rd);
    assign mem_hit = src_hit(id_rs, id_use_rs, mem_rd) || src_hit(id_rt, id_use_rt, mem_rd);

    assign load_use = ex_memread && ex_hit;

    // Branches resolve in ID, so they also wait on an ALU result still in EX and
    // on a load still in MEM; a load in EX thus costs two re-evaluated stall cycles.
    assign branch_dep = id_branch && ((ex_regwrite && ex_hit) || (mem_memread && mem_hit));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch stalls, redirect flush, multi-cycle mul/div freeze.
// Latency: controls are combinational from state and inputs; mul/div freeze lasts MD_LAT cycles after md_start.
// Backpressure: ext_stall holds every pipeline register and suppresses all clears; the mul/div counter keeps running.
//   ports: clk, rst_n (synchronous, active-low), pif (pipe_ctrl_if.slave)
//   optional (PIPE_CTRL_PERF_EN defined): stall_cycles, flush_count 32-bit wrapping counters
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_ctrl_if.slave    pif
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count
`endif
);

    localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use, branch_dep;

    hazard_detect u_hazard (
        .id_rs       (pif.id_rs),
        .id_rt       (pif.id_rt),
        .id_use_rs   (pif.id_use_rs),
        .id_use_rt   (pif.id_use_rt),
        .id_branch   (pif.id_branch),
        .ex_rd       (pif.ex_rd),
        .ex_regwrite (pif.ex_regwrite),
        .ex_memread  (pif.ex_memread),
        .mem_rd      (pif.mem_rd),
        .mem_memread (pif.mem_memread),
        .load_use    (load_use),
        .branch_dep  (branch_dep)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: independent of ext_stall so the mul/div unit keeps counting
    // while memory is waiting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (pif.md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output controls. Priority: reset, ext_stall, mul/div freeze, data stall, redirect.
    // Each branch drives at most one of hold/clear per stage.
    always_comb begin
        pif.pc_hold     = 1'b0;
        pif.ifid_hold   = 1'b0;
        pif.ifid_clear  = 1'b0;
        pif.idex_hold   = 1'b0;
        pif.idex_clear  = 1'b0;
        pif.exmem_hold  = 1'b0;
        pif.exmem_clear = 1'b0;
        pif.memwb_hold  = 1'b0;
        pif.md_done     = 1'b0;
        pif.busy        = 1'b0;

        if (!rst_n) begin
            pif.ifid_clear  = 1'b1;
            pif.idex_clear  = 1'b1;
            pif.exmem_clear = 1'b1;
        end else begin
            pif.busy    = (state_q != RUN);
            pif.md_done = (state_q == MD_BUSY) && (cnt_q == 8'd0);

            if (pif.ext_stall) begin
                pif.pc_hold    = 1'b1;
                pif.ifid_hold  = 1'b1;
                pif.idex_hold  = 1'b1;
                pif.exmem_hold = 1'b1;
                pif.memwb_hold = 1'b1;
            end else if (state_q == MD_BUSY || pif.md_start) begin
                // Freeze the front end behind the mul/div and bubble into MEM.
                pif.pc_hold     = 1'b1;
                pif.ifid_hold   = 1'b1;
                pif.idex_hold   = 1'b1;
                pif.exmem_clear = 1'b1;
            end else if (load_use || branch_dep) begin
                pif.pc_hold    = 1'b1;
                pif.ifid_hold  = 1'b1;
                pif.idex_clear = 1'b1;
            end else if (pif.br_taken || pif.jump) begin
                pif.ifid_clear = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pif.pc_hold)    stall_cycles <= stall_cycles + 32'd1;
            if (pif.ifid_clear) flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with MD_LAT = 4.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_ctrl;
    import cpu_pkg::*;

    // Control vector bit order:
    // {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
    //  exmem_hold, exmem_clear, memwb_hold, md_done, busy}
    localparam logic [9:0] C_NONE   = 10'b00_0000_0000;
    localparam logic [9:0] C_RESET  = 10'b00_1010_1000;
    localparam logic [9:0] C_STALL  = 10'b11_0010_0000;
    localparam logic [9:0] C_REDIR  = 10'b00_1000_0000;
    localparam logic [9:0] C_MDSTRT = 10'b11_0100_1000;
    localparam logic [9:0] C_MDBUSY = 10'b11_0100_1001;
    localparam logic [9:0] C_MDDONE = 10'b11_0100_1011;
    localparam logic [9:0] C_EXT    = 10'b11_0101_0100;
    localparam logic [9:0] C_EXTB   = 10'b11_0101_0101;
    localparam logic [9:0] C_EXTBD  = 10'b11_0101_0111;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipe_ctrl_if pif ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    pipe_ctrl #(.MD_LAT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pif          (pif.slave)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctl();
        return {pif.pc_hold, pif.ifid_hold, pif.ifid_clear, pif.idex_hold, pif.idex_clear,
                pif.exmem_hold, pif.exmem_clear, pif.memwb_hold, pif.md_done, pif.busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then compare the control vector.
    task automatic chk_ctl(input string tag, input logic [9:0] exp);
        #2;
        chk(tag, {22'd0, ctl()}, {22'd0, exp});
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pif.id_rs       = R0;
        pif.id_rt       = R0;
        pif.id_use_rs   = 1'b0;
        pif.id_use_rt   = 1'b0;
        pif.id_branch   = 1'b0;
        pif.ex_rd       = R0;
        pif.ex_regwrite = 1'b0;
        pif.ex_memread  = 1'b0;
        pif.mem_rd      = R0;
        pif.mem_memread = 1'b0;
        pif.br_taken    = 1'b0;
        pif.jump        = 1'b0;
        pif.md_start    = 1'b0;
        pif.ext_stall   = 1'b0;
    endtask

    task automatic ex_load(input reg_t rd);
        pif.ex_rd       = rd;
        pif.ex_regwrite = 1'b1;
        pif.ex_memread  = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst_n = 1'b0;
        #1;
        chk_ctl("reset_outputs", C_RESET);
        cyc();
        cyc();
        rst_n = 1'b1;
        chk_ctl("idle_after_reset", C_NONE);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_reset", stall_cycles, 32'd0);
        chk("perf_flush_reset", flush_count, 32'd0);
`endif

        // lw $2 in EX, add $3,$2,$4 in ID: one stall, then the load moves to MEM
        cyc();
        ex_load(5'd2);
        pif.id_rs = 5'd2; pif.id_use_rs = 1'b1;
        pif.id_rt = 5'd4; pif.id_use_rt = 1'b1;
        chk_ctl("loaduse_stall", C_STALL);
        cyc();
        pif.ex_rd = R0; pif.ex_regwrite = 1'b0; pif.ex_memread = 1'b0;
        pif.mem_rd = 5'd2; pif.mem_memread = 1'b1;
        chk_ctl("loaduse_released", C_NONE);

        // unused source does not match
        cyc();
        idle();
        ex_load(5'd2);
        pif.id_rs = 5'd2; pif.id_use_rs = 1'b0;
        chk_ctl("unused_src_no_stall", C_NONE);

        // lw $2 in EX, beq $2,$0 in ID: two stall cycles
        cyc();
        idle();
        ex_load(5'd2);
        pif.id_branch = 1'b1;
        pif.id_rs = 5'd2; pif.id_use_rs = 1'b1;
        pif.id_rt = R0;   pif.id_use_rt = 1'b1;
        chk_ctl("branch_load_stall1", C_STALL);
        cyc();
        pif.ex_rd = R0; pif.ex_regwrite = 1'b0; pif.ex_memread = 1'b0;
        pif.mem_rd = 5'd2; pif.mem_memread = 1'b1;
        chk_ctl("branch_load_stall2", C_STALL);
        cyc();
        pif.mem_rd = R0; pif.mem_memread = 1'b0;
        chk_ctl("branch_load_release", C_NONE);

        // same branch against a load to r0: no hazard
        cyc();
        ex_load(R0);
        pif.id_rs = R0;
        chk_ctl("branch_r0_no_stall", C_NONE);

        // branch on an ALU result in EX stalls; a non-branch user does not
        cyc();
        idle();
        pif.ex_rd = 5'd5; pif.ex_regwrite = 1'b1;
        pif.id_rs = 5'd5; pif.id_use_rs = 1'b1;
        pif.id_branch = 1'b1;
        chk_ctl("branch_alu_stall", C_STALL);
        cyc();
        pif.id_branch = 1'b0;
        chk_ctl("alu_forward_no_stall", C_NONE);

        // redirects
        cyc();
        idle();
        pif.br_taken = 1'b1;
        chk_ctl("br_taken_flush", C_REDIR);
        cyc();
        pif.br_taken = 1'b0;
        pif.jump = 1'b1;
        chk_ctl("jump_flush", C_REDIR);
        cyc();
        pif.jump = 1'b0;
        pif.br_taken = 1'b1;
        ex_load(5'd7);
        pif.id_rt = 5'd7; pif.id_use_rt = 1'b1;
        chk_ctl("br_taken_with_loaduse", C_STALL);

        // mul/div, MD_LAT = 4; redirects ignored while busy
        cyc();
        idle();
        pif.md_start = 1'b1;
        chk_ctl("md_start", C_MDSTRT);
        cyc();
        pif.md_start = 1'b0;
        pif.br_taken = 1'b1;
        chk_ctl("md_busy1", C_MDBUSY);
        cyc();
        chk_ctl("md_busy2", C_MDBUSY);
        cyc();
        pif.md_start = 1'b1;
        ex_load(5'd3);
        pif.id_rs = 5'd3; pif.id_use_rs = 1'b1;
        chk_ctl("md_busy3_hazards_ignored", C_MDBUSY);
        cyc();
        idle();
        pif.br_taken = 1'b1;
        chk_ctl("md_done", C_MDDONE);
        cyc();
        pif.br_taken = 1'b0;
        chk_ctl("md_back_to_run", C_NONE);

        // ext_stall during MD_BUSY: holds only, md_done still on schedule
        cyc();
        pif.md_start = 1'b1;
        chk_ctl("md2_start", C_MDSTRT);
        cyc();
        pif.md_start = 1'b0;
        pif.ext_stall = 1'b1;
        chk_ctl("ext_busy1", C_EXTB);
        cyc();
        chk_ctl("ext_busy2", C_EXTB);
        cyc();
        chk_ctl("ext_busy3", C_EXTB);
        cyc();
        chk_ctl("ext_md_done", C_EXTBD);
        cyc();
        ex_load(5'd9);
        pif.id_rs = 5'd9; pif.id_use_rs = 1'b1;
        pif.jump = 1'b1;
        chk_ctl("ext_run_overrides", C_EXT);
        cyc();
        idle();
        chk_ctl("ext_released", C_NONE);

        // reset mid-MD_BUSY aborts without md_done
        cyc();
        pif.md_start = 1'b1;
        chk_ctl("md3_start", C_MDSTRT);
        cyc();
        pif.md_start = 1'b0;
        chk_ctl("md3_busy1", C_MDBUSY);
        cyc();
        rst_n = 1'b0;
        chk_ctl("md3_reset_low", C_RESET);
        cyc();
        chk_ctl("md3_reset_low2", C_RESET);
        cyc();
        rst_n = 1'b1;
        chk_ctl("md3_after_reset_run", C_NONE);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_after_abort", stall_cycles, 32'd0);
`endif
        cyc();
        chk_ctl("md3_no_late_done", C_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 32, mul/div latency in cycles (legal 2..255).
REQ-002 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each  sources of the ID instruction; id_use_rs, id_use_rt  in  1 each  source-valid flags.
REQ-005 SHALL have port id_branch  in  1  the ID instruction is a BEQ/BNE resolved in ID.
REQ-006 SHALL have ports ex_rd  in  5; ex_regwrite  in  1; ex_memread  in  1  destination and kind of the EX instruction.
REQ-007 SHALL have ports mem_rd  in  5; mem_memread  in  1  destination and load flag of the MEM instruction.
REQ-008 SHALL have ports br_taken, jump  in  1 each  redirect from ID; md_start  in  1  mul/div entering EX; ext_stall  in  1  memory wait.
REQ-009 SHALL have outputs pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear, exmem_hold, exmem_clear, memwb_hold  1 each  controls for pipeline registers; md_done  out  1  one-cycle completion pulse; busy  out  1  state != RUN.

Function
REQ-010 SHALL implement FSM states RUN and MD_BUSY with an 8-bit down-counter cnt.
REQ-011 Register r0 SHALL never cause a hazard (rd == 0 ignored).
REQ-012 Load-use: in RUN, ex_memread & ex_rd matches a used ID source SHALL assert pc_hold, ifid_hold, idex_clear for that cycle.
REQ-013 Branch dependency: in RUN, id_branch with a used source matching ex_rd (ex_regwrite) or mem_rd (mem_memread) SHALL assert pc_hold, ifid_hold, idex_clear; a load in EX therefore stalls 2 cycles via re-evaluation.
REQ-014 Redirect: in RUN with no stall of REQ-012/013, br_taken | jump SHALL assert ifid_clear only.
REQ-015 md_start in RUN SHALL move to MD_BUSY, load cnt = MD_LAT-1, and assert pc_hold, ifid_hold, idex_hold, exmem_clear that cycle.
REQ-016 In MD_BUSY SHALL assert pc_hold, ifid_hold, idex_hold, exmem_clear; br_taken, jump, md_start and data hazards ignored; cnt decrements each cycle.
REQ-017 When cnt == 0 in MD_BUSY SHALL pulse md_done for that cycle and return to RUN next edge; total stall = MD_LAT cycles.
REQ-018 ext_stall SHALL assert every hold output and suppress every clear, overriding REQ-012..016; cnt continues counting, and md_done may pulse during ext_stall.
REQ-019 No stage SHALL ever see its hold and clear asserted together.
REQ-020 Outputs SHALL be combinational from state and inputs; only state, cnt and optional counters are registered.

Reset
REQ-021 While rst_n low at a rising edge, state SHALL become RUN, cnt 0, optional counters 0.
REQ-022 While rst_n is low, all hold outputs, md_done and busy SHALL be 0 and all clear outputs 1.
REQ-023 Reset during MD_BUSY SHALL abort the operation without a md_done pulse.

Configuration
REQ-024 With PIPE_CTRL_PERF_EN defined SHALL add outputs stall_cycles and flush_count, 32 bits each, wrapping at 2^32; stall_cycles increments on any cycle with pc_hold, and flush_count increments on any cycle with ifid_clear and rst_n high.
REQ-025 Without PIPE_CTRL_PERF_EN those ports and registers SHALL not exist; other behaviour is identical.

Structure
REQ-026 State encoding, register-number width (5) and the r0 constant SHALL live in a shared package cpu_pkg.
REQ-027 A sub-module hazard_detect SHALL hold the combinational source/destination comparisons of REQ-011..013; FSM and counters stay in pipe_ctrl.

Verification
REQ-028 lw $2 in EX, add $3,$2,$4 in ID -> exactly 1 cycle of pc_hold/ifid_hold/idex_clear, then no stall.
REQ-029 lw $2 in EX, beq $2,$0 in ID -> stall 2 consecutive cycles; with ex_rd = 0 -> no stall.
REQ-030 br_taken = 1 with no hazard -> ifid_clear = 1 and no hold for one cycle; with a load-use in the same cycle -> stall only, no ifid_clear.
REQ-031 md_start with MD_LAT = 4 -> busy for 4 cycles and md_done on the 4th; br_taken during MD_BUSY is ignored.
REQ-032 ext_stall during MD_BUSY (MD_LAT = 4) -> all holds set and no clears; md_done still fires 4 cycles after md_start.
REQ-033 rst_n low mid-MD_BUSY -> RUN next edge, all clears 1 while low, no md_done; with PIPE_CTRL_PERF_EN, stall_cycles preset to 0xFFFFFFFF wraps to 0 after one stall.
